// File: rtl/decompressor_unpacker.sv
// decompressor_unpacker: byte-buffers packed compressed records and expands one tagged record per cycle
module decompressor_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DATA   = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int BUF_BYTES  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [255:0]                   data_in,
  input  logic                           tvalid_in,
  input  logic                           tlast_in,
  input  logic [31:0]                    tkeep_in,
  output logic                           tready_out,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic                           tvalid_out,
  output logic                           tlast_out,
  input  logic                           tready_in,
  output logic                           err_out
);
  localparam int BW = 8 * BUF_BYTES;
  localparam int CW = $clog2(BUF_BYTES + 1);
  localparam int SW = $clog2(BW);
  typedef enum logic {FILL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] buf_q, buf_d, in_ext;
  logic [CW-1:0] count_q, count_d, rec_len, in_bytes, shift, base, off;
  logic [DATA_WIDTH*NUM_DATA-1:0] data_q, expanded;
  logic [TAG_WIDTH-1:0] t;
  logic [DATA_WIDTH-1:0] raw, mask;
  logic tvalid_q, tlast_q, err_q;
  logic have_rec, fire, accept, flush;
  // Expand the record at the head of the buffer; payload offsets are a running sum of tag sizes
  always_comb begin
    off = '0;
    expanded = '0;
    t = '0;
    raw = '0;
    mask = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      t = buf_q[i*TAG_WIDTH +: TAG_WIDTH];
      raw = buf_q[SW'({off + CW'(2), 3'b000}) +: DATA_WIDTH];
      mask = (t == 2'b11) ? '1 : (t == 2'b10) ? DATA_WIDTH'(16'hFFFF) : (t == 2'b01) ? DATA_WIDTH'(8'hFF) : '0;
      expanded[i*DATA_WIDTH +: DATA_WIDTH] = raw & mask;
      off = off + ((t == 2'b11) ? CW'(4) : CW'(t));
    end
    rec_len = off + CW'(2);
  end
  // Count kept bytes and zero the unkept ones so bytes above count stay zero
  always_comb begin
    in_bytes = '0;
    in_ext = '0;
    for (int k = 0; k < 32; k++) begin
      in_bytes = in_bytes + CW'(tkeep_in[k]);
      in_ext[8*k +: 8] = tkeep_in[k] ? data_in[8*k +: 8] : 8'h00;
    end
  end
  assign have_rec   = count_q >= CW'(2) && count_q >= rec_len;
  assign fire       = have_rec && (!tvalid_q || tready_in);
  assign tready_out = !reset && state_q == FILL && count_q <= CW'(32);
  assign accept     = tvalid_in && tready_out;
  assign flush      = state_q == DRAIN && count_q != '0 && !have_rec;
  assign shift      = fire ? rec_len : '0;
  assign base       = count_q - shift;
  // Buffer shifts out a fired record and appends new bytes right after what remains
  always_comb begin
    buf_d = flush ? '0 : (buf_q >> {shift, 3'b000}) | (accept ? (in_ext << {base, 3'b000}) : '0);
    count_d = flush ? '0 : base + (accept ? in_bytes : '0);
    state_d = (state_q == FILL) ? ((accept && tlast_in) ? DRAIN : FILL) : ((count_q == '0 || flush) ? FILL : DRAIN);
  end
  // Buffer, byte count and packet state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      buf_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      count_q <= count_d;
    end
  end
  // Output beat register; held while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (fire) begin
        data_q <= expanded;
        tlast_q <= state_q == DRAIN && rec_len == count_q;
      end
      tvalid_q <= fire || (tvalid_q && !tready_in);
      err_q <= flush;
    end
  end
  assign data_out   = data_q;
  assign tvalid_out = tvalid_q;
  assign tlast_out  = tlast_q;
  assign err_out    = err_q;
endmodule

// File: tb/tb_decompressor_unpacker.sv
// tb_decompressor_unpacker: directed table and corner-case sequences for the record unpacker
module tb_decompressor_unpacker;
  logic clk = 1'b0;
  logic reset;
  logic [255:0] data_in;
  logic tvalid_in, tlast_in, tready_in;
  logic [31:0] tkeep_in;
  logic tready_out, tvalid_out, tlast_out, err_out;
  logic [255:0] data_out;
  int checks = 0;
  int errors = 0;
  int n_valid, n_last, n_err, first_valid, last_valid_idx;
  logic last_tlast;
  logic [255:0] cap;
  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic [255:0] e;
    int           nv;
    int           ne;
  } vec_t;
  vec_t vt[6];
  decompressor_unpacker dut (
    .clk(clk), .reset(reset), .data_in(data_in), .tvalid_in(tvalid_in), .tlast_in(tlast_in),
    .tkeep_in(tkeep_in), .tready_out(tready_out), .data_out(data_out), .tvalid_out(tvalid_out),
    .tlast_out(tlast_out), .tready_in(tready_in), .err_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l, output logic ok);
    data_in = d;
    tkeep_in = k;
    tlast_in = l;
    tvalid_in = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (tready_out) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    tvalid_in = 1'b0;
    tlast_in = 1'b0;
  endtask
  task automatic observe(input int n);
    n_valid = 0; n_last = 0; n_err = 0; first_valid = -1; last_valid_idx = -1; last_tlast = 1'b0; cap = '0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      if (tvalid_out && tready_in) begin
        if (first_valid < 0) begin
          first_valid = c;
          cap = data_out;
        end
        n_valid++;
        last_valid_idx = c;
        last_tlast = tlast_out;
        if (tlast_out) n_last++;
      end
      if (err_out) n_err++;
    end
  endtask
  initial begin
    logic ok;
    logic [255:0] d, e;
    int held;
    reset = 1'b1; data_in = '0; tvalid_in = 1'b0; tlast_in = 1'b0; tkeep_in = '0; tready_in = 1'b1;
    for (int v = 0; v < 6; v++) begin
      vt[v].d = '0; vt[v].e = '0; vt[v].k = '0; vt[v].nv = 0; vt[v].ne = 0;
    end
    vt[0].k = 32'h3; vt[0].nv = 1;
    vt[1].d[15:0] = 16'h5555; vt[1].k = 32'h3FF; vt[1].nv = 1;
    for (int j = 0; j < 8; j++) begin
      vt[1].d[8*(2+j) +: 8] = 8'(j + 1);
      vt[1].e[32*j +: 32] = 32'(j + 1);
    end
    vt[2].d[15:0] = 16'hAAAA; vt[2].k = 32'h3FFFF; vt[2].nv = 1;
    for (int j = 0; j < 16; j++) vt[2].d[8*(2+j) +: 8] = 8'(8'h10 + j);
    for (int j = 0; j < 8; j++) vt[2].e[32*j +: 32] = {16'h0, 8'(8'h11 + 2*j), 8'(8'h10 + 2*j)};
    vt[3].d[15:0] = 16'hFFFF; vt[3].k = 32'h7F; vt[3].ne = 1;
    for (int j = 0; j < 5; j++) vt[3].d[8*(2+j) +: 8] = 8'(8'hA0 + j);
    vt[4].d[71:0] = 72'h44_33_22_11_EF_CD_AB_00_E4; vt[4].k = 32'h1FF; vt[4].nv = 1;
    vt[4].e[127:32] = {32'h44332211, 32'h0000EFCD, 32'h000000AB};
    repeat (2) @(negedge clk);
    chk("reset data_out", data_out, '0);
    chk("reset tvalid_out", tvalid_out, 0);
    chk("reset tlast_out", tlast_out, 0);
    chk("reset err_out", err_out, 0);
    chk("reset tready_out", tready_out, 0);
    reset = 1'b0;
    #1 chk("tready after release", tready_out, 1);
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      send(vt[v].d, vt[v].k, 1'b1, ok);
      chk($sformatf("v%0d accept", v), ok, 1);
      observe(8);
      chk($sformatf("v%0d valid count", v), n_valid, vt[v].nv);
      chk($sformatf("v%0d err count", v), n_err, vt[v].ne);
      if (vt[v].nv > 0) begin
        chk($sformatf("v%0d data", v), cap, vt[v].e);
        chk($sformatf("v%0d latency", v), first_valid, 1);
        chk($sformatf("v%0d tlast count", v), n_last, 1);
      end
    end
    tready_in = 1'b0;
    send('0, 32'hFFFF_FFFF, 1'b1, ok);
    chk("bp accept", ok, 1);
    @(negedge clk);
    held = 0;
    for (int c = 0; c < 10; c++) begin
      if (tvalid_out && !tlast_out && data_out == '0) held++;
      @(negedge clk);
    end
    chk("bp held cycles", held, 10);
    chk("bp tready_out in drain", tready_out, 0);
    tready_in = 1'b1;
    observe(20);
    chk("bp handshakes", n_valid, 16);
    chk("bp first at release", first_valid, 0);
    chk("bp back-to-back end", last_valid_idx, 15);
    chk("bp tlast count", n_last, 1);
    chk("bp tlast on last", last_tlast, 1);
    d = '0;
    d[15:0] = 16'hFFFF;
    for (int j = 0; j < 30; j++) d[8*(2+j) +: 8] = 8'(j);
    for (int j = 0; j < 32; j++) e[8*j +: 8] = 8'(j);
    send(d, 32'hFFFF_FFFF, 1'b0, ok);
    chk("two-beat beat1 accept", ok, 1);
    send({240'h0, 16'h1F1E}, 32'h3, 1'b1, ok);
    chk("two-beat beat2 accept", ok, 1);
    chk("two-beat tready after tlast", tready_out, 0);
    observe(6);
    chk("two-beat valid count", n_valid, 1);
    chk("two-beat data", cap, e);
    chk("two-beat latency", first_valid, 1);
    chk("two-beat tlast", n_last, 1);
    chk("two-beat err", n_err, 0);
    send(d, 32'hFFFF_FFFF, 1'b0, ok);
    chk("rst beat1 accept", ok, 1);
    reset = 1'b1;
    #1;
    chk("midrst data_out", data_out, '0);
    chk("midrst tvalid_out", tvalid_out, 0);
    chk("midrst tlast_out", tlast_out, 0);
    chk("midrst err_out", err_out, 0);
    chk("midrst tready_out", tready_out, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("midrst tready after release", tready_out, 1);
    @(negedge clk);
    send({232'h0, 24'h5A_00_01}, 32'h7, 1'b1, ok);
    chk("post-rst accept", ok, 1);
    observe(6);
    chk("post-rst valid count", n_valid, 1);
    chk("post-rst data", cap, 256'h5A);
    chk("post-rst tlast", n_last, 1);
    chk("post-rst err", n_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
